sqd_serializer: RTL and testbench

Parallel-to-serial front end for the bit-sequence detector. Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per CLK, on X_OUT; X_OUT drives the detector's X input directly. A one-word holding register lets back-to-back words stream with no idle cycle between frames.

---
 rtl/sqd_serializer.sv | 123 ++++++++++++
 tb/tb_sqd_serializer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sqd_serializer.sv
// sqd_serializer: parallel-to-serial front end for the bit-sequence detector.
// Words arrive over a valid/ready handshake into a one-word holding register,
// are moved into the shift register, and go out MSB-first, one bit per CLK.
// The holding register lets the next word be loaded on the same edge that
// retires the last bit, so frames stream back-to-back with no gap.
// Optional feature macro: SQD_SER_PARITY_EN appends an even-parity bit
// after each word's LSB (frame length WIDTH+1 instead of WIDTH).
module sqd_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             DATA_VALID,
  output logic             DATA_READY,
  output logic             X_OUT,
  output logic             BIT_VALID,
  output logic             FRAME_DONE,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SQD_SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hold;
  logic             hold_v;
  logic             shift_end;
  logic             last;
  logic             xfer;
  logic             accept;
`ifdef SQD_SER_PARITY_EN
  logic             par_q;
`endif

  // Frame-end and handshake decode; all from registers (plus RESET_N gating
  // of READY), never from DATA_VALID or DATA_IN.
  always_comb begin
    shift_end = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
`ifdef SQD_SER_PARITY_EN
    last      = (state == PARITY);
`else
    last      = shift_end;
`endif
    xfer       = hold_v && ((state == IDLE) || last);
    DATA_READY = RESET_N && (!hold_v || xfer);
    accept     = DATA_VALID && DATA_READY;
  end

  // Serial output decode: MSB of the shifter, the parity bit, or 0 when idle.
  always_comb begin
    X_OUT = 1'b0;
    case (state)
      SHIFT:   X_OUT = sr[WIDTH-1];
`ifdef SQD_SER_PARITY_EN
      PARITY:  X_OUT = par_q;
`endif
      default: X_OUT = 1'b0;
    endcase
    BIT_VALID  = (state != IDLE);
    FRAME_DONE = last;
    BUSY       = (state != IDLE) || hold_v;
  end

  // Holding register, shifter and frame FSM. A transfer takes priority over
  // normal shifting; it can only coincide with the last bit of a frame, so
  // the shift it overrides would have been discarded anyway.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      hold   <= '0;
      hold_v <= 1'b0;
`ifdef SQD_SER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        hold   <= DATA_IN;
        hold_v <= 1'b1;
      end else if (xfer) begin
        hold_v <= 1'b0;
      end

      if (xfer) begin
        sr    <= hold;
        cnt   <= '0;
        state <= SHIFT;
`ifdef SQD_SER_PARITY_EN
        // The shifter is consumed bit by bit, so capture the word's parity now.
        par_q <= ^hold;
`endif
      end else begin
        case (state)
          SHIFT: begin
            sr  <= sr << 1;
            cnt <= cnt + CW'(1);
            if (shift_end) begin
`ifdef SQD_SER_PARITY_EN
              state <= PARITY;
`else
              state <= IDLE;
`endif
            end
          end
`ifdef SQD_SER_PARITY_EN
          PARITY:  state <= IDLE;
`endif
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sqd_serializer.sv
// Directed bench for sqd_serializer: reset, single frame latency/shape,
// back-to-back streaming, stall with changing DATA_IN, mid-frame reset,
// parity frames (when SQD_SER_PARITY_EN is defined) and a random stream
// with idle gaps checked against an expected bit queue.
module tb_sqd_serializer;
  localparam int W = 8;
`ifdef SQD_SER_PARITY_EN
  localparam int L = W + 1;
`else
  localparam int L = W;
`endif

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic [W-1:0] DATA_IN = '0;
  logic         DATA_VALID = 1'b0;
  logic         DATA_READY, X_OUT, BIT_VALID, FRAME_DONE, BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] wq[$];
  bit           eb[$];

  sqd_serializer #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY), .X_OUT(X_OUT), .BIT_VALID(BIT_VALID),
    .FRAME_DONE(FRAME_DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Append a word's data bits (MSB first) plus the given parity bit if framed.
  task automatic push_word(input logic [W-1:0] w, input bit p);
    for (int b = W - 1; b >= 0; b--) eb.push_back(w[b]);
`ifdef SQD_SER_PARITY_EN
    eb.push_back(p);
`endif
  endtask

  // Offer the words in wq and check the serial stream against eb.
  // Without gaps the source keeps DATA_VALID high and the bit stream must be
  // contiguous; with gaps DATA_VALID is randomly withheld between words.
  task automatic stream_check(input string tag, input bit gaps);
    int wi = 0;
    int pos = 0;
    int cyc = 0;
    bit started = 0;
    bit acc;
    DATA_IN    = wq[0];
    DATA_VALID = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
    while (eb.size() > 0 && cyc < 20000) begin
      acc = DATA_VALID && DATA_READY;
      step();
      cyc++;
      if (acc) wi++;
      if (wi >= wq.size()) begin
        DATA_VALID = 1'b0;
      end else begin
        DATA_IN = wq[wi];
        if (!gaps) DATA_VALID = 1'b1;
        else if (acc || !DATA_VALID) DATA_VALID = ($urandom_range(0, 2) != 0);
      end
      if (BIT_VALID) begin
        started = 1;
        chk({tag, "_bit"}, X_OUT, eb.pop_front());
        chk({tag, "_done"}, FRAME_DONE, (pos % L) == (L - 1));
        pos++;
      end else begin
        chk({tag, "_idle_x"}, X_OUT, 1'b0);
        chk({tag, "_idle_done"}, FRAME_DONE, 1'b0);
        if (!gaps && started) chk({tag, "_gap"}, BIT_VALID, 1'b1);
      end
    end
    chk({tag, "_drained"}, eb.size(), 0);
    chk({tag, "_accepts"}, wi, wq.size());
    DATA_VALID = 1'b0;
    step();
    chk({tag, "_end_bv"}, BIT_VALID, 1'b0);
    chk({tag, "_end_busy"}, BUSY, 1'b0);
  endtask

  initial begin
    logic [W-1:0] b5;
    logic [W-1:0] rw;
    bit           fd_seen;

    // Reset state
    RESET_N = 1'b0;
    step(); step(); step();
    chk("rst_ready", DATA_READY, 1'b0);
    chk("rst_x", X_OUT, 1'b0);
    chk("rst_bv", BIT_VALID, 1'b0);
    chk("rst_done", FRAME_DONE, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    RESET_N = 1'b1;
    #1;
    chk("rel_ready", DATA_READY, 1'b1);

    // Single frame 8'hB5: 2-cycle latency, L bits, FRAME_DONE on the last
    b5 = 8'hB5;
    DATA_IN = b5; DATA_VALID = 1'b1;
    step();                        // edge k: accept
    DATA_VALID = 1'b0;
    chk("b5_lat_bv", BIT_VALID, 1'b0);
    chk("b5_busy", BUSY, 1'b1);
    for (int i = 0; i < L; i++) begin
      step();
      chk("b5_bv", BIT_VALID, 1'b1);
      chk("b5_x", X_OUT, (i < W) ? b5[W-1-i] : 1'b1);
      chk("b5_done", FRAME_DONE, i == L - 1);
    end
    step();
    chk("b5_after_x", X_OUT, 1'b0);
    chk("b5_after_bv", BIT_VALID, 1'b0);
    chk("b5_after_done", FRAME_DONE, 1'b0);
    chk("b5_after_busy", BUSY, 1'b0);

    // Back-to-back streaming of A5, 3C, FF (parities 0, 0, 0)
    wq = '{8'hA5, 8'h3C, 8'hFF};
    eb.delete();
    push_word(8'hA5, 1'b0); push_word(8'h3C, 1'b0); push_word(8'hFF, 1'b0);
    stream_check("strm", 1'b0);

    // Stall: C3 shifting, 5A held, 77 offered while not ready, 0F taken
    DATA_IN = 8'hC3; DATA_VALID = 1'b1;
    step();                        // edge k: accept C3
    chk("stl_ready_k", DATA_READY, 1'b1);
    DATA_IN = 8'h5A;
    step();                        // edge k+1: C3 to shifter, 5A to HOLD
    chk("stl_first_x", X_OUT, 1'b1);
    chk("stl_first_bv", BIT_VALID, 1'b1);
    DATA_IN = 8'h77;
    fd_seen = 0;
    for (int i = 0; i < L + 2 && !fd_seen; i++) begin
      if (FRAME_DONE) begin
        fd_seen = 1;
        chk("stl_ready_last", DATA_READY, 1'b1);
        DATA_IN = 8'h0F;
      end else begin
        chk("stl_ready_low", DATA_READY, 1'b0);
        step();
      end
    end
    chk("stl_fd_seen", fd_seen, 1'b1);
    step();                        // accepts 0F; 5A MSB now on X_OUT
    DATA_VALID = 1'b0;
    eb.delete();
    push_word(8'h5A, 1'b0); push_word(8'h0F, 1'b0);
    for (int i = 0; i < 2 * L; i++) begin
      chk("stl_bv", BIT_VALID, 1'b1);
      chk("stl_x", X_OUT, eb.pop_front());
      step();
    end
    chk("stl_end_bv", BIT_VALID, 1'b0);
    chk("stl_end_busy", BUSY, 1'b0);

    // Reset during the 4th bit of F0 with 3C held
    DATA_IN = 8'hF0; DATA_VALID = 1'b1;
    step();
    DATA_IN = 8'h3C;
    step();                        // bit 1 of F0; 3C accepted
    DATA_VALID = 1'b0;
    step(); step(); step();        // bit 4 on X_OUT
    chk("mr_bit4_x", X_OUT, 1'b1);
    chk("mr_bit4_busy", BUSY, 1'b1);
    RESET_N = 1'b0;
    step();
    chk("mr_x", X_OUT, 1'b0);
    chk("mr_bv", BIT_VALID, 1'b0);
    chk("mr_busy", BUSY, 1'b0);
    chk("mr_done", FRAME_DONE, 1'b0);
    chk("mr_ready", DATA_READY, 1'b0);
    RESET_N = 1'b1;
    #1;
    chk("mr_rel_ready", DATA_READY, 1'b1);
    wq = '{8'h81};
    eb.delete();
    push_word(8'h81, 1'b0);
    stream_check("mr81", 1'b0);

`ifdef SQD_SER_PARITY_EN
    // Parity frames: B5 carries parity 1, 03 carries parity 0
    wq = '{8'hB5, 8'h03};
    eb.delete();
    push_word(8'hB5, 1'b1); push_word(8'h03, 1'b0);
    stream_check("par", 1'b0);
`endif

    // Random words with random idle gaps
    wq.delete();
    eb.delete();
    for (int i = 0; i < 60; i++) begin
      rw = W'($urandom);
      wq.push_back(rw);
      push_word(rw, ^rw);
    end
    stream_check("rnd", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
